// File: rtl/pc_unit.sv
// Program-counter stage of the IF pipeline stage.
// Holds the fetch address and selects the next PC. The choices are a sequential
// PC+4, a jump target, or a branch target built from PC+4 plus a word-aligned
// offset. The stage also honours stall/enable, and detects halt and end-of-program.
module pc_unit #(
    parameter int unsigned           DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0]   PC_RESET = '0,
    parameter logic [DATA_LEN-1:0]   PC_LIMIT = DATA_LEN'(1024)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_branch_taken,
    input  logic [DATA_LEN-1:0] i_branch_base,
    input  logic [DATA_LEN-1:0] i_branch_offset,
    input  logic                i_jump,
    input  logic [DATA_LEN-1:0] i_jump_addr,
    output logic [DATA_LEN-1:0] o_pc,
    output logic [DATA_LEN-1:0] o_pc_plus4,
    output logic                o_redirect,
    output logic                o_halted,
    output logic                o_misaligned
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_LEN-1:0] pc_q;
    logic [DATA_LEN-1:0] seq_pc;
    logic [DATA_LEN-1:0] branch_target;
    logic [DATA_LEN-1:0] redirect_target;
    logic                do_update;
    logic                do_redirect;

    // Candidate next-PC values and redirect selection (jump beats branch).
    always_comb begin
        seq_pc          = pc_q + DATA_LEN'(4);
        branch_target   = i_branch_base + i_branch_offset;
        do_update       = i_enable && !i_stall;
        do_redirect     = i_jump || i_branch_taken;
        redirect_target = i_jump ? i_jump_addr : branch_target;
    end

    // PC register and RUN/HALTED control, with all status outputs registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= RUN;
            pc_q         <= PC_RESET;
            o_redirect   <= 1'b0;
            o_halted     <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_redirect <= 1'b0;
            case (state)
                RUN: begin
                    if (do_update) begin
                        if (i_halt) begin
                            state    <= HALTED;
                            o_halted <= 1'b1;
                        end else if (do_redirect) begin
                            pc_q <= redirect_target;
                            if (redirect_target[1:0] != 2'b00) begin
                                o_misaligned <= 1'b1;
                            end
                            if (redirect_target >= PC_LIMIT) begin
                                state    <= HALTED;
                                o_halted <= 1'b1;
                            end else begin
                                o_redirect <= 1'b1;
                            end
                        end else begin
                            pc_q <= seq_pc;
                            if (seq_pc >= PC_LIMIT) begin
                                state    <= HALTED;
                                o_halted <= 1'b1;
                            end
                        end
                    end
                end
                HALTED: begin
                    o_halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_q + DATA_LEN'(4);

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit. The main instance uses the default PC_LIMIT.
// A second instance uses PC_LIMIT=0x20 and exercises end-of-program.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        stall;
    logic        halt;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump;
    logic [31:0] jump_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        halted;
    logic        misaligned;

    logic        rst2_n;
    logic [31:0] pc2;
    logic [31:0] pc2_plus4;
    logic        redirect2;
    logic        halted2;
    logic        misaligned2;

    int tests_run;
    int tests_failed;

    pc_unit #(.DATA_LEN(32), .PC_RESET(32'h0), .PC_LIMIT(32'd1024)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_stall(stall),
        .i_halt(halt), .i_branch_taken(branch_taken), .i_branch_base(branch_base),
        .i_branch_offset(branch_offset), .i_jump(jump), .i_jump_addr(jump_addr),
        .o_pc(pc), .o_pc_plus4(pc_plus4), .o_redirect(redirect),
        .o_halted(halted), .o_misaligned(misaligned)
    );

    pc_unit #(.DATA_LEN(32), .PC_RESET(32'h0), .PC_LIMIT(32'h20)) dut_lim (
        .i_clk(clk), .i_rst_n(rst2_n), .i_enable(1'b1), .i_stall(1'b0),
        .i_halt(1'b0), .i_branch_taken(1'b0), .i_branch_base(32'h0),
        .i_branch_offset(32'h0), .i_jump(1'b0), .i_jump_addr(32'h0),
        .o_pc(pc2), .o_pc_plus4(pc2_plus4), .o_redirect(redirect2),
        .o_halted(halted2), .o_misaligned(misaligned2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        halt          = 1'b0;
        branch_taken  = 1'b0;
        branch_base   = '0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_addr     = '0;
        stall         = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        enable = 1'b1;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        // Present a redirect while in reset; reset must win.
        jump      = 1'b1;
        jump_addr = 32'h0000_0200;
        step();
        step();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_misaligned", {31'b0, misaligned}, 32'h0);
        check("rst2_pc", pc2, 32'h0);

        // Sequential fetch
        idle_inputs();
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_pc", pc, 32'(4 * i));
            check("seq_pc_plus4", pc_plus4, 32'(4 * i + 4));
            check("seq_redirect", {31'b0, redirect}, 32'h0);
        end
        check("lim_pc_before", pc2, 32'h14);
        check("lim_halted_before", {31'b0, halted2}, 32'h0);

        // Re-reset the main instance, then run up to 0x10
        rst_n = 1'b0;
        step();
        check("rerst_pc", pc, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("pre_branch_pc", pc, 32'h10);
        check("lim_pc_end", pc2, 32'h20);
        check("lim_halted_end", {31'b0, halted2}, 32'h1);

        // Forward branch with shifted offset
        branch_taken  = 1'b1;
        branch_base   = 32'h14;
        branch_offset = 32'h40;
        step();
        check("br_fwd_pc", pc, 32'h54);
        check("br_fwd_redirect", {31'b0, redirect}, 32'h1);
        idle_inputs();
        step();
        check("br_fwd_next_pc", pc, 32'h58);
        check("br_fwd_redirect_drop", {31'b0, redirect}, 32'h0);

        // Backward branch (negative offset)
        branch_taken  = 1'b1;
        branch_base   = 32'h20;
        branch_offset = 32'hFFFF_FFF0;
        step();
        check("br_back_pc", pc, 32'h10);
        check("br_back_redirect", {31'b0, redirect}, 32'h1);

        // Jump and branch together: the jump wins
        jump          = 1'b1;
        jump_addr     = 32'h100;
        branch_taken  = 1'b1;
        branch_base   = 32'h20;
        branch_offset = 32'h40;
        step();
        check("conflict_pc", pc, 32'h100);
        check("conflict_redirect", {31'b0, redirect}, 32'h1);
        idle_inputs();
        step();
        check("conflict_next_pc", pc, 32'h104);
        check("aligned_no_mis", {31'b0, misaligned}, 32'h0);

        // Stall and enable hold at 0x8
        jump      = 1'b1;
        jump_addr = 32'h8;
        step();
        check("jmp8_pc", pc, 32'h8);
        idle_inputs();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h8);
            check("stall_redirect", {31'b0, redirect}, 32'h0);
        end
        stall  = 1'b0;
        enable = 1'b0;
        step();
        check("dis_pc", pc, 32'h8);
        halt = 1'b1;
        step();
        check("dis_pc2", pc, 32'h8);
        check("dis_halt_ignored", {31'b0, halted}, 32'h0);
        halt   = 1'b0;
        enable = 1'b1;
        step();
        check("release_pc", pc, 32'hC);

        // HALT instruction
        jump      = 1'b1;
        jump_addr = 32'h24;
        step();
        idle_inputs();
        check("pre_halt_pc", pc, 32'h24);
        halt = 1'b1;
        step();
        check("halt_pc", pc, 32'h24);
        check("halt_halted", {31'b0, halted}, 32'h1);
        idle_inputs();
        jump          = 1'b1;
        jump_addr     = 32'h200;
        branch_taken  = 1'b1;
        branch_base   = 32'h40;
        branch_offset = 32'h40;
        for (int i = 0; i < 2; i++) begin
            step();
            check("halted_pc_frozen", pc, 32'h24);
            check("halted_stays", {31'b0, halted}, 32'h1);
            check("halted_no_redirect", {31'b0, redirect}, 32'h0);
        end
        idle_inputs();
        rst_n = 1'b0;
        step();
        check("halt_rst_pc", pc, 32'h0);
        check("halt_rst_halted", {31'b0, halted}, 32'h0);
        rst_n = 1'b1;

        // Redirect beyond the limit ends execution
        jump      = 1'b1;
        jump_addr = 32'h400;
        step();
        check("jmp_limit_pc", pc, 32'h400);
        check("jmp_limit_halted", {31'b0, halted}, 32'h1);
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Misaligned jump target: loaded unmodified, flag sticky
        jump      = 1'b1;
        jump_addr = 32'h102;
        step();
        check("mis_pc", pc, 32'h102);
        check("mis_flag", {31'b0, misaligned}, 32'h1);
        check("mis_redirect", {31'b0, redirect}, 32'h1);
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            step();
            check("mis_sticky", {31'b0, misaligned}, 32'h1);
            check("mis_seq_pc", pc, 32'(32'h102 + 4 * i));
        end
        jump      = 1'b1;
        jump_addr = 32'h200;
        rst_n     = 1'b0;
        step();
        check("mis_rst_pc", pc, 32'h0);
        check("mis_rst_flag", {31'b0, misaligned}, 32'h0);
        check("mis_rst_redirect", {31'b0, redirect}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
